ysyx_2022040010_shift_pipe: RTL
===============================

// Module: ysyx_2022040010_shift_pipe
// PURPOSE
//  Pipelined, parametrised barrel shifter for the EXU. Executes SLL/SRL/SRA/ROL/ROR,
//  with RV64 word (*W) forms. Amount is masked to legal width. The shift is split over
//  STAGES register stages to cut critical-path delay. Valid/ready on both sides, a tag
//  that travels with each op, and a flush that kills in-flight ops on redirect.
// PARAMETERS
//  XLEN    64  datapath width; power of two, >= 32
//  STAGES  2   pipeline register stages, 1..$clog2(XLEN); latency = STAGES cycles
//  TAG_W   5   width of opaque tag carried alongside each op (e.g. rd index)
//  HAS_W   1   1 = word mode honoured (requires XLEN=64); 0 = in_w ignored
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous reset, active low
//  flush      in   1       kill every in-flight op (synchronous)
//  in_valid   in   1       op present on in_*
//  in_ready   out  1       stage 0 can accept this cycle
//  in_op      in   3       000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others reserved
//  in_w       in   1       word mode: operate on [31:0], sign-extend 32-bit result
//  in_src     in   XLEN    operand to shift
//  in_shamt   in   XLEN    shift amount; only low bits used (see below)
//  in_tag     in   TAG_W   passed through unchanged
//  out_valid  out  1       result present
//  out_ready  in   1       consumer takes result this cycle
//  out_result out  XLEN    shifted value
//  out_tag    out  TAG_W   tag of the op in out_result
// BEHAVIOUR
//  Reset (rst_n=0, async): all stage valid bits 0, so out_valid=0. Data, tag and op
//   registers cleared to 0; out_result=0, out_tag=0. in_ready=0 while rst_n=0, 1 after.
//  Amount: SW=$clog2(XLEN); effective shamt = in_shamt[SW-1:0], or in_shamt[4:0] if in_w.
//  Word mode operand: SRA uses sign = in_src[31] and fills from bit 31. SLL/SRL/ROL/ROR
//   act on zero-extended [31:0]; rotates wrap within 32 bits. Final result =
//   {{32{r[31]}}, r[31:0]}.
//  Normal mode: SRA fills with in_src[XLEN-1]; ROL/ROR wrap within XLEN. shamt=0 -> src.
//  Reserved op codes: result 0; tag and handshake behave normally.
//  Datapath: left ops use bit-reverse / right-shift / bit-reverse. Each stage handles a
//   disjoint subset of amount bits, bit i going to stage floor(i*STAGES/SW). Mode, op and
//   remaining amount ride the pipeline.
//   Sign extension for word mode is applied in the last stage.
//  Pipeline flow: each stage s holds v[s]. Stage s advances when v[s] and (s is last ?
//   out_ready : stage s+1 free or advancing). in_ready = !v[0] | stage 0 advancing,
//   with the same advance rule. Full throughput: 1 op/cycle when out_ready stays 1.
//  Latency: accept in cycle N -> out_valid in cycle N+STAGES with no stall.
//  Stall: out_valid=1 & out_ready=0 -> out_result/out_tag held stable. Upstream stages
//   fill; no op lost, duplicated or reordered. Capacity = STAGES ops.
//  Flush: on the flush edge all v[] clear; out_valid=0 the next cycle. in_ready=0 during
//   flush, so no op is accepted that cycle; in_valid with flush is dropped. A result
//   handshaken in the flush cycle (out_valid&out_ready) counts as delivered.
//  Reset mid-operation: in-flight ops discarded immediately; no partial output after release.
// TESTING (XLEN=64, STAGES=2 unless noted)
//  SRA src=8000_0000_0000_0000 shamt=4 -> F800_0000_0000_0000 on out_valid 2 cycles later
//  SLL src=1 shamt=65 (masked to 1) -> 2; ROR src=1 shamt=1 -> 8000_0000_0000_0000
//  SLLW src=1 shamt=31 -> FFFF_FFFF_8000_0000; SRAW src=8000_0000 shamt=36 (->4) ->
//   FFFF_FFFF_F800_0000; SRLW src=FFFF_FFFF_8000_0000 shamt=31 -> 1
//  Back-to-back 4 ops, tags 1..4, out_ready=0 cycles 2-5: in_ready drops after 2 accepts.
//   Outputs stay stable and deliver tags 1,2,3,4 in order once out_ready=1.
//  Flush with 2 ops in flight and in_valid=1: out_valid=0 next cycle, neither flushed op
//   ever appears. The concurrent input is not accepted. Next op has latency 2.
//  rst_n low for 1 cycle with 2 ops in flight -> out_valid=0 at once, out_result=0.
//   Sweep STAGES=1,3,6 with random ops vs golden model: results and latency match.

Source files
------------

// File: rtl/ysyx_2022040010_shift_pipe.sv
// Pipelined barrel shifter for SLL/SRL/SRA/ROL/ROR and RV64 word forms; result STAGES cycles after accept.
// Valid/ready on both sides: a stalled output holds steady while upstream stages fill; flush kills in-flight ops.
module ysyx_2022040010_shift_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5,
  parameter int HAS_W  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic             in_w,
  input  logic [XLEN-1:0]  in_src,
  input  logic [XLEN-1:0]  in_shamt,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int SW   = $clog2(XLEN);
  localparam int LAST = STAGES - 1;

  function automatic logic [XLEN-1:0] rev_f(input logic [XLEN-1:0] d, input logic w);
    logic [XLEN-1:0] r;
    r = '0;
    if (w) for (int i = 0; i < 32; i++) r[i] = d[31-i];
    else   for (int i = 0; i < XLEN; i++) r[i] = d[XLEN-1-i];
    return r;
  endfunction

  // One right shift/rotate by a power of two; word mode stays inside the low 32 bits.
  function automatic logic [XLEN-1:0] step_f(input logic [XLEN-1:0] d, input int sh,
                                             input logic rot, input logic fill, input logic w);
    logic [XLEN-1:0] r;
    logic [31:0]     lo;
    if (w) begin
      lo = d[31:0];
      lo = rot ? ((lo >> sh) | (lo << (32 - sh)))
               : ((lo >> sh) | (~(32'hFFFF_FFFF >> sh) & {32{fill}}));
      r = '0;
      r[31:0] = lo;
    end else begin
      r = rot ? ((d >> sh) | (d << (XLEN - sh)))
              : ((d >> sh) | (~({XLEN{1'b1}} >> sh) & {XLEN{fill}}));
    end
    return r;
  endfunction

  function automatic logic [XLEN-1:0] sext_f(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = {XLEN{d[31]}};
    r[31:0] = d[31:0];
    return r;
  endfunction

  logic            p_w, p_left, p_rot, p_rsv, p_fill;
  logic [SW-1:0]   p_amt;
  logic [XLEN-1:0] p_base, p_dat;
  logic            unused_shamt;

  assign unused_shamt = ^in_shamt[XLEN-1:SW];

  always_comb begin
    p_w    = (HAS_W != 0) && in_w;
    p_left = (in_op == 3'b000) || (in_op == 3'b011);
    p_rot  = (in_op == 3'b011) || (in_op == 3'b100);
    p_rsv  = in_op > 3'b100;
    p_amt  = in_shamt[SW-1:0] & (p_w ? SW'(31) : {SW{1'b1}});
    p_base = in_src;
    if (p_w) begin
      p_base = '0;
      p_base[31:0] = in_src[31:0];
    end
    p_fill = (in_op == 3'b010) && (p_w ? in_src[31] : in_src[XLEN-1]);
    // Left ops run through the right-shift network between two bit reversals.
    p_dat  = p_left ? rev_f(p_base, p_w) : p_base;
  end

  logic [STAGES-1:0] v_q, v_d, adv, take;
  logic              room, accept;
  logic [XLEN-1:0]   dat_q [STAGES];
  logic [XLEN-1:0]   dat_d [STAGES];
  logic [XLEN-1:0]   din   [STAGES];
  logic [SW-1:0]     amt_q [STAGES];
  logic [SW-1:0]     ain   [STAGES];
  logic              rot_q [STAGES], rin [STAGES];
  logic              fill_q[STAGES], fin [STAGES];
  logic              w_q   [STAGES], win [STAGES];
  logic              left_q[STAGES], lin [STAGES];
  logic              rsv_q [STAGES], xin [STAGES];
  logic [TAG_W-1:0]  tag_q [STAGES], tin [STAGES];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [XLEN-1:0] nx;

    if (s == 0) begin : g_src_in
      assign din[s] = p_dat;  assign ain[s] = p_amt;  assign rin[s] = p_rot;
      assign fin[s] = p_fill; assign win[s] = p_w;    assign lin[s] = p_left;
      assign xin[s] = p_rsv;  assign tin[s] = in_tag;
    end else begin : g_src_reg
      assign din[s] = dat_q[s-1];  assign ain[s] = amt_q[s-1];  assign rin[s] = rot_q[s-1];
      assign fin[s] = fill_q[s-1]; assign win[s] = w_q[s-1];    assign lin[s] = left_q[s-1];
      assign xin[s] = rsv_q[s-1];  assign tin[s] = tag_q[s-1];
    end

    // Amount bit i belongs to stage floor(i*STAGES/SW).
    always_comb begin
      nx = din[s];
      for (int i = 0; i < SW; i++)
        if (((i * STAGES) / SW == s) && ain[s][i]) nx = step_f(nx, 1 << i, rin[s], fin[s], win[s]);
      if (s == LAST) begin
        if (lin[s]) nx = rev_f(nx, win[s]);
        if (win[s]) nx = sext_f(nx);
        if (xin[s]) nx = '0;
      end
    end

    assign dat_d[s] = nx;
  end

  // Walk from the output back: a stage advances when the one after it has room.
  always_comb begin
    room = out_ready;
    adv  = '0;
    for (int s = LAST; s >= 0; s--) begin
      adv[s] = v_q[s] & room;
      room   = ~v_q[s] | adv[s];
    end
  end

  assign in_ready = rst_n & ~flush & room;
  assign accept   = in_valid & in_ready;
  assign take     = (adv << 1) | STAGES'(accept);
  assign v_d      = flush ? '0 : (take | (v_q & ~adv));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s]  <= '0;   amt_q[s]  <= '0;   rot_q[s] <= 1'b0; fill_q[s] <= 1'b0;
        w_q[s]    <= 1'b0; left_q[s] <= 1'b0; rsv_q[s] <= 1'b0; tag_q[s]  <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int s = 0; s < STAGES; s++) begin
        if (take[s]) begin
          dat_q[s]  <= dat_d[s]; amt_q[s]  <= ain[s]; rot_q[s] <= rin[s]; fill_q[s] <= fin[s];
          w_q[s]    <= win[s];   left_q[s] <= lin[s]; rsv_q[s] <= xin[s]; tag_q[s]  <= tin[s];
        end
      end
    end
  end

  assign out_valid  = v_q[LAST];
  assign out_result = dat_q[LAST];
  assign out_tag    = tag_q[LAST];

endmodule
